// File: rtl/dlx_pkg.sv
// Shared DLX definitions: op kinds, opcode/func constants, ALU codes.
// Used by both the decoder and the instruction encoder.
package dlx_pkg;

    typedef enum logic [3:0] {
        K_NOP   = 4'd0,
        K_R_ALU = 4'd1,
        K_I_ALU = 4'd2,
        K_LW    = 4'd3,
        K_SW    = 4'd4,
        K_BEQZ  = 4'd5,
        K_BNEZ  = 4'd6,
        K_LHI   = 4'd7,
        K_JR    = 4'd8,
        K_JALR  = 4'd9,
        K_J     = 4'd10,
        K_JAL   = 4'd11
    } enc_kind_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ENC  = 2'd1,
        S_WR   = 2'd2
    } enc_state_t;

    typedef enum logic [1:0] {
        RNG_NONE = 2'd0,
        RNG_S16  = 2'd1,
        RNG_U16  = 2'd2,
        RNG_S26  = 2'd3
    } rng_t;

    typedef struct packed {
        logic       ok;
        logic [5:0] code;
    } code_t;

    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SRL = 4'd7;
    localparam logic [3:0] ALU_SEQ = 4'd10;
    localparam logic [3:0] ALU_SLE = 4'd11;
    localparam logic [3:0] ALU_SLT = 4'd12;
    localparam logic [3:0] ALU_SNE = 4'd13;
    localparam logic [3:0] ALU_SRA = 4'd14;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] OP_BEQZ    = 6'h04;
    localparam logic [5:0] OP_BNEZ    = 6'h05;
    localparam logic [5:0] OP_LHI     = 6'h0F;
    localparam logic [5:0] OP_JR      = 6'h12;
    localparam logic [5:0] OP_JALR    = 6'h13;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;

    // R-type func field for an ALU code; ok=0 when unmapped
    function automatic code_t alu_func(input logic [3:0] a);
        code_t c;
        c = '{ok: 1'b1, code: 6'h00};
        case (a)
            ALU_ADD: c.code = 6'h20;
            ALU_SUB: c.code = 6'h22;
            ALU_AND: c.code = 6'h24;
            ALU_OR:  c.code = 6'h25;
            ALU_XOR: c.code = 6'h26;
            ALU_SLL: c.code = 6'h04;
            ALU_SRL: c.code = 6'h06;
            ALU_SEQ: c.code = 6'h28;
            ALU_SLE: c.code = 6'h2C;
            ALU_SLT: c.code = 6'h2A;
            ALU_SNE: c.code = 6'h29;
            ALU_SRA: c.code = 6'h07;
            default: c.ok   = 1'b0;
        endcase
        return c;
    endfunction

    // I-type opcode for an ALU code; ok=0 when unmapped
    function automatic code_t alu_iop(input logic [3:0] a);
        code_t c;
        c = '{ok: 1'b1, code: 6'h00};
        case (a)
            ALU_ADD: c.code = 6'h08;
            ALU_SUB: c.code = 6'h0A;
            ALU_AND: c.code = 6'h0C;
            ALU_OR:  c.code = 6'h0D;
            ALU_XOR: c.code = 6'h0E;
            ALU_SLL: c.code = 6'h14;
            ALU_SRL: c.code = 6'h16;
            ALU_SEQ: c.code = 6'h18;
            ALU_SLE: c.code = 6'h1C;
            ALU_SLT: c.code = 6'h1A;
            ALU_SNE: c.code = 6'h19;
            ALU_SRA: c.code = 6'h17;
            default: c.ok   = 1'b0;
        endcase
        return c;
    endfunction

    // Which immediate range an op must respect
    function automatic rng_t imm_class(input logic [3:0] k,
                                       input logic [3:0] a);
        rng_t r;
        r = RNG_NONE;
        case (k)
            K_I_ALU: r = (a inside {ALU_ADD, ALU_SUB, ALU_SEQ,
                                    ALU_SLE, ALU_SLT, ALU_SNE})
                         ? RNG_S16 : RNG_U16;
            K_LW, K_SW, K_BEQZ, K_BNEZ: r = RNG_S16;
            K_LHI, K_JR, K_JALR:        r = RNG_U16;
            K_J, K_JAL:                 r = RNG_S26;
            default:                    r = RNG_NONE;
        endcase
        return r;
    endfunction

    function automatic logic imm_fits(input rng_t r, input logic [31:0] v);
        logic f;
        case (r)
            RNG_S16: f = (v[31:15] == '0) || (v[31:15] == '1);
            RNG_U16: f = (v[31:16] == '0);
            RNG_S26: f = (v[31:25] == '0) || (v[31:25] == '1);
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational DLX word packer with unencodable-op flag.
// Optional immediate range checking: define ENC_RANGE_CHECK_EN.
module instr_pack
    import dlx_pkg::*;
(
    input  logic [3:0]  i_kind,
    input  logic [3:0]  i_alu,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_iv,
    output logic [31:0] o_word,
    output logic        o_err
);

    logic [31:0] w_word;
    logic        w_bad;
    logic        w_oor;
    code_t       w_c;

    // Field packing per op kind
    always_comb begin
        w_word = '0;
        w_bad  = 1'b0;
        w_c    = '0;
        case (i_kind)
            K_NOP: w_word = '0;
            K_R_ALU: begin
                w_c    = alu_func(i_alu);
                w_bad  = !w_c.ok;
                w_word = {OP_SPECIAL, i_rs1, i_rs2, i_rd, 5'd0, w_c.code};
            end
            K_I_ALU: begin
                w_c    = alu_iop(i_alu);
                w_bad  = !w_c.ok;
                w_word = {w_c.code, i_rs1, i_rd, i_iv[15:0]};
            end
            K_LW:   w_word = {OP_LW, i_rs1, i_rd, i_iv[15:0]};
            K_SW:   w_word = {OP_SW, i_rs1, i_rs2, i_iv[15:0]};
            K_BEQZ: w_word = {OP_BEQZ, i_rs1, 5'd0, i_iv[15:0]};
            K_BNEZ: w_word = {OP_BNEZ, i_rs1, 5'd0, i_iv[15:0]};
            K_LHI:  w_word = {OP_LHI, 5'd0, i_rd, i_iv[15:0]};
            K_JR:   w_word = {OP_JR, i_rs1, 5'd0, i_iv[15:0]};
            K_JALR: w_word = {OP_JALR, i_rs1, 5'd0, i_iv[15:0]};
            K_J:    w_word = {OP_J, i_iv[25:0]};
            K_JAL:  w_word = {OP_JAL, i_iv[25:0]};
            default: w_bad = 1'b1;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    assign w_oor = !imm_fits(imm_class(i_kind, i_alu), i_iv);
`else
    // Immediates silently truncate to their field width
    logic w_unused_iv;
    assign w_unused_iv = ^i_iv[31:26];
    assign w_oor = 1'b0;
`endif

    assign o_err  = w_bad | w_oor;
    assign o_word = o_err ? 32'h0 : w_word;

endmodule

// File: rtl/instr_encoder.sv
// DLX instruction encoder: IDLE/ENC/WR handshake FSM writing packed
// words to sequential instruction-memory addresses.
module instr_encoder
    import dlx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_base,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op_kind,
    input  logic [3:0]  I,
    input  logic [4:0]  Rs1,
    input  logic [4:0]  Rs2,
    input  logic [4:0]  Rd,
    input  logic [31:0] Iv,
    output logic [31:0] i_address,
    output logic [31:0] i_data_write,
    output logic        i_write_enable,
    output logic [15:0] word_count,
    output logic        err
);

    enc_state_t  r_state;
    enc_state_t  w_next;
    logic        w_hs;
    logic [3:0]  r_kind;
    logic [3:0]  r_alu;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic [31:0] r_iv;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [15:0] r_cnt;
    logic        r_err;
    logic [31:0] w_word;
    logic        w_perr;

    instr_pack u_pack (
        .i_kind (r_kind),
        .i_alu  (r_alu),
        .i_rs1  (r_rs1),
        .i_rs2  (r_rs2),
        .i_rd   (r_rd),
        .i_iv   (r_iv),
        .o_word (w_word),
        .o_err  (w_perr)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state, handshake and write strobe; load_base aborts
    always_comb begin
        w_next         = r_state;
        in_ready       = 1'b0;
        i_write_enable = 1'b0;
        if (!reset && !load_base) begin
            case (r_state)
                S_IDLE: begin
                    in_ready = 1'b1;
                    if (in_valid) w_next = S_ENC;
                end
                S_ENC: w_next = S_WR;
                S_WR: begin
                    i_write_enable = 1'b1;
                    w_next         = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end else begin
            w_next = S_IDLE;
        end
    end

    assign w_hs = in_valid & in_ready;

    // Op fields are captured only on an accepted handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            r_kind <= '0;
            r_alu  <= '0;
            r_rs1  <= '0;
            r_rs2  <= '0;
            r_rd   <= '0;
            r_iv   <= '0;
        end else if (w_hs) begin
            r_kind <= op_kind;
            r_alu  <= I;
            r_rs1  <= Rs1;
            r_rs2  <= Rs2;
            r_rd   <= Rd;
            r_iv   <= Iv;
        end
    end

    // Address, data word, count and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= '0;
            r_data <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else if (load_base) begin
            r_addr <= base_addr;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == S_ENC) begin
                r_data <= w_word;
                if (w_perr) r_err <= 1'b1;
            end
            if (i_write_enable) begin
                r_addr <= r_addr + 32'd4;
                r_cnt  <= r_cnt + 16'd1;
            end
        end
    end

    assign i_address    = r_addr;
    assign i_data_write = r_data;
    assign word_count   = r_cnt;
    assign err          = r_err;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have port load_base, input, 1 bit: load write address and clear status.
REQ-004 SHALL have port base_addr, input, 32 bits: start address for load_base.
REQ-005 SHALL have port in_valid, input, 1 bit: decoded-op fields are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: encoder accepts a new op.
REQ-007 SHALL have port op_kind, input, 4 bits: op class, enc_kind_t from the package.
REQ-008 SHALL have port I, input, 4 bits: ALU operation code, same coding the decoder emits.
REQ-009 SHALL have ports Rs1, Rs2 and Rd, input, 5 bits each: register indices.
REQ-010 SHALL have port Iv, input, 32 bits: immediate or offset value.
REQ-011 SHALL have port i_address, output, 32 bits: instruction-memory write address.
REQ-012 SHALL have port i_data_write, output, 32 bits: encoded instruction word.
REQ-013 SHALL have port i_write_enable, output, 1 bit: single-cycle write strobe.
REQ-014 SHALL have port word_count, output, 16 bits: words written since load_base.
REQ-015 SHALL have port err, output, 1 bit: sticky; set on any unencodable op.

Function
REQ-016 SHALL run a 3-state FSM:
- IDLE: in_ready=1.
- IDLE to ENC on in_valid and in_ready; fields latched.
- ENC to WR: word computed and registered.
- WR to IDLE: i_write_enable=1 for exactly one cycle; i_address then += 4; word_count += 1, wrapping at 0xFFFF.
REQ-017 SHALL use fixed timing: handshake at cycle N gives the write strobe at N+2; throughput is one op per 3 cycles.
REQ-018 SHALL encode R_ALU as opcode 0x00, rs1 in [25:21], rs2 in [20:16], rd in [15:11], func in [5:0]. I to func: 1=0x20, 2=0x22, 3=0x24, 4=0x25, 5=0x26, 6=0x04, 7=0x06, 10=0x28, 11=0x2C, 12=0x2A, 13=0x29, 14=0x07.
REQ-019 SHALL encode I_ALU as rs1 in [25:21], rd in [20:16], Iv[15:0] in [15:0]. I to opcode: 1=0x08, 2=0x0A, 3=0x0C, 4=0x0D, 5=0x0E, 6=0x14, 7=0x16, 10=0x18, 11=0x1C, 12=0x1A, 13=0x19, 14=0x17.
REQ-020 SHALL encode the remaining kinds as follows:
- LW 0x23: rd in [20:16].
- SW 0x2B: rs2 in [20:16].
- BEQZ 0x04 and BNEZ 0x05: rs1 in [25:21], Iv[15:0].
- LHI 0x0F: rd in [20:16], Iv[15:0].
- JR 0x12 and JALR 0x13: rs1 in [25:21], Iv[15:0].
- J 0x02 and JAL 0x03: Iv[25:0].
- NOP: 0x00000000.
REQ-021 SHALL write 0x00000000 and set err for an I code unmapped in REQ-018/019, or an undefined op_kind; address and count still advance.
REQ-022 SHALL, when load_base is asserted in any state:
- take priority over FSM activity;
- load i_address from base_addr;
- clear word_count and err;
- abort any pending write and return to IDLE.
REQ-023 SHALL ignore in_valid when in_ready=0; the latched fields SHALL NOT change outside IDLE.

Reset
REQ-024 SHALL, on reset:
- go to IDLE;
- clear i_address, i_data_write, word_count, err and i_write_enable;
- set in_ready=1 on the cycle after reset deasserts.
REQ-025 SHALL give reset priority over load_base and in_valid.

Configuration
REQ-026 SHALL, with ENC_RANGE_CHECK_EN defined, check immediate range:
- 16-bit signed for ADDI, SUBI, SEQI..SLEI, LW, SW and branches;
- 16-bit unsigned for ANDI, ORI, XORI, shifts, LHI, JR and JALR;
- 26-bit signed for J and JAL;
- out of range: write 0x00000000 and set err.
REQ-027 SHALL, without ENC_RANGE_CHECK_EN, truncate Iv to the field width silently with no err.

Structure
REQ-028 SHALL take enc_kind_t, the opcode/func constants and the I-code constants from the shared package dlx_pkg, which the decoder SHALL also use.
REQ-029 SHALL place the word computation in the combinational sub-module instr_pack; the FSM, counters and handshake stay in instr_encoder.

Verification
REQ-030 SHALL cover R_ALU: I=1, Rs1=1, Rs2=2, Rd=3 -> 0x00221820 written at base_addr two cycles after the handshake.
REQ-031 SHALL cover I_ALU: I=1, Rs1=0, Rd=5, Iv=0xFFFFFFFF -> 0x2005FFFF at base_addr+4; word_count=2.
REQ-032 SHALL cover SW: Rs1=1, Rs2=2, Iv=8 -> 0xAC220008; J with Iv=0x10 -> 0x08000010.
REQ-033 SHALL cover R_ALU with I=9 -> 0x00000000 written and err=1; a later load_base clears err and word_count.
REQ-034 SHALL cover ADDI with Iv=0x00012345 -> with ENC_RANGE_CHECK_EN: 0x00000000 and err=1; without it: 0x20052345 and err=0.
REQ-035 SHALL cover load_base asserted during WR -> no write strobe, i_address=base_addr, IDLE next cycle.
